// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl - multiply/divide unit controller for the five-stage MIPS pipeline.
//
// Accepts mult/multu/div/divu/mthi/mtlo from the EX stage. Arithmetic results
// are computed combinationally at issue and parked in pend_hi/pend_lo. A 4-bit
// busy counter then models the fixed unit latency. HI/LO are updated when the
// counter expires. A combinational stall request holds any ID-stage MDU
// instruction while an operation is in flight or being issued.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports:
//   clk        in   pipeline clock, rising edge
//   reset      in   asynchronous active-low reset, clears all state
//   start      in   EX-stage MDU instruction valid
//   op[2:0]    in   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   a, b       in   forwarded rs / rt values
//   md_use_ID  in   ID-stage instruction uses the MDU
//   busy       out  operation in flight
//   stall      out  stall request to the hazard unit
//   hi, lo     out  HI / LO registers
//
// Build option:
//   MDU_DIVZERO_FAST_EN  when defined, a divide by zero finishes after a single
//                        busy cycle instead of DIV_CYCLES.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_ID,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  // Arithmetic datapath
  logic        signed_op;
  logic        b_zero;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] mag_a, mag_b, uq, ur, div_q, div_r;
  logic [3:0]  div_load;

  always_comb begin
    // op[0]==0 selects the signed flavour for both mult and div.
    signed_op = ~op[0];
    b_zero    = (b == 32'd0);

    // Low 64 bits of the product of sign/zero-extended operands equal the
    // exact signed/unsigned 32x32 product.
    mul_a = {{32{signed_op & a[31]}}, a};
    mul_b = {{32{signed_op & b[31]}}, b};
    prod  = mul_a * mul_b;

    // Signed divide done on magnitudes so 0x80000000 / -1 never overflows:
    // |0x80000000| is representable as an unsigned 32-bit value.
    mag_a = (signed_op & a[31]) ? (32'd0 - a) : a;
    mag_b = (signed_op & b[31]) ? (32'd0 - b) : b;
    uq    = b_zero ? 32'd0 : (mag_a / mag_b);
    ur    = b_zero ? 32'd0 : (mag_a % mag_b);
    div_q = (signed_op & (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    div_r = (signed_op & a[31]) ? (32'd0 - ur) : ur;

`ifdef MDU_DIVZERO_FAST_EN
    div_load = b_zero ? 4'd1 : DIV_LOAD;
`else
    div_load = DIV_LOAD;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero commits the current HI/LO back, i.e. no change.
              pend_hi_d = b_zero ? hi_q : div_r;
              pend_lo_d = b_zero ? lo_q : div_q;
              cnt_d     = div_load;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; the hazard unit never issues during RUN.
        if (cnt_q <= 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  // Stall covers the issue cycle as well, before busy has risen.
  assign stall = md_use_ID & (busy | (start & ~op[2]));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
